// File: rtl/debounce_pkg.sv
// Shared types and constant helpers for the multi-channel button debouncer.
package debounce_pkg;

  // Per-channel hold tracking: idle, waiting for the long-press time, or auto-repeating.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  // Number of clock cycles in a span of milliseconds at an integer-MHz clock.
  function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                               input int unsigned clk_mhz);
    return ms * clk_mhz * 32'd1000;
  endfunction

  // Bits needed for a counter that must hold the value x (clog2 of x+1).
  function automatic int unsigned cnt_width(input int unsigned x);
    return unsigned'($clog2(x + 32'd1));
  endfunction

  // Larger of two unsigned values, used to size the shared hold counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce counter, hold FSM and
// registered event pulses. Timing comes from the shared ms_tick_i strobe.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ms_tick_i,
  input  logic btn_i,
  output logic btn_level_o,
  output logic btn_press_o,
  output logic btn_release_o,
  output logic btn_long_o,
  output logic btn_repeat_o
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_MS);
  localparam int unsigned HOLD_W = cnt_width(max_u(LONG_MS, REPEAT_MS));
  localparam bit          REPEAT_EN = (REPEAT_MS > 0);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 32'd1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MS - 32'd1);
  localparam logic [HOLD_W-1:0] REP_LAST  =
    HOLD_W'((REPEAT_MS > 0) ? (REPEAT_MS - 32'd1) : 32'd0);

  // ------------------------------------------------------------------
  // Input path
  // ------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       s;

  // Two-flop synchroniser on the polarity-corrected raw input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i ^ ACTIVE_LOW};
    end
  end

  assign s = sync_q[1];

  // ------------------------------------------------------------------
  // Debounce
  // ------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            rise_d, fall_d;

  // Count whole ms ticks during which s disagrees with the accepted level;
  // any agreement restarts the count, so bounces never accumulate.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s == level_q) begin
      db_cnt_d = '0;
    end else if (ms_tick_i) begin
      if (db_cnt_q == DB_LAST) begin
        level_d  = s;
        db_cnt_d = '0;
        rise_d   = s;
        fall_d   = ~s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state plus the registered level and edge pulses; the level
  // and its edge pulse become visible in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_cnt_q      <= '0;
      level_q       <= 1'b0;
      btn_press_o   <= 1'b0;
      btn_release_o <= 1'b0;
    end else begin
      db_cnt_q      <= db_cnt_d;
      level_q       <= level_d;
      btn_press_o   <= rise_d;
      btn_release_o <= fall_d;
    end
  end

  assign btn_level_o = level_q;

  // ------------------------------------------------------------------
  // Hold FSM
  // ------------------------------------------------------------------
  hold_state_t       state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              frozen_q;   // long already fired with repeat disabled

  // The FSM starts from the registered press pulse so that only ticks
  // strictly after the press cycle are counted. A release being accepted
  // this cycle wins over any expiry on the same tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      frozen_q     <= 1'b0;
      btn_long_o   <= 1'b0;
      btn_repeat_o <= 1'b0;
    end else begin
      btn_long_o   <= 1'b0;
      btn_repeat_o <= 1'b0;
      if (fall_d) begin
        state_q    <= IDLE;
        hold_cnt_q <= '0;
        frozen_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (btn_press_o) begin
              state_q    <= HELD;
              hold_cnt_q <= '0;
              frozen_q   <= 1'b0;
            end
          end
          HELD: begin
            if (ms_tick_i && !frozen_q) begin
              if (hold_cnt_q == LONG_LAST) begin
                btn_long_o <= 1'b1;
                hold_cnt_q <= '0;
                if (REPEAT_EN) begin
                  state_q <= REPEAT;
                end else begin
                  frozen_q <= 1'b1;
                end
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (ms_tick_i) begin
              if (hold_cnt_q == REP_LAST) begin
                btn_repeat_o <= 1'b1;
                hold_cnt_q   <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            frozen_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel button debouncer: one shared 1 ms prescaler feeding N
// independent debounce_channel instances.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DEBOUNCE_MS  = 10,
  parameter int unsigned CLK_FREQ_MHZ = 50,
  parameter int unsigned LONG_MS      = 1000,
  parameter int unsigned REPEAT_MS    = 200,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic            clk_50MHz,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic [N_CH-1:0] btn_repeat
);

  localparam int unsigned TICK_CYCLES = ms_to_cycles(32'd1, CLK_FREQ_MHZ);
  localparam int unsigned PRE_W       = cnt_width(TICK_CYCLES);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 32'd1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             ms_tick;

  // Tick on the last count of each millisecond, then wrap.
  always_comb begin
    ms_tick   = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = ms_tick ? '0 : (pre_cnt_q + 1'b1);
  end

  // Shared millisecond prescaler.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      debounce_channel #(
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS),
        .REPEAT_MS   (REPEAT_MS),
        .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_ch (
        .clk_i         (clk_50MHz),
        .rst_i         (rst),
        .ms_tick_i     (ms_tick),
        .btn_i         (btn_in[gi]),
        .btn_level_o   (btn_level[gi]),
        .btn_press_o   (btn_press[gi]),
        .btn_release_o (btn_release[gi]),
        .btn_long_o    (btn_long[gi]),
        .btn_repeat_o  (btn_repeat[gi])
      );
    end
  endgenerate

endmodule
